// File: rtl/leaves_pkg.sv
// leaves_pkg: shared types, state encoding and default sizes for the leaf loader
package leaves_pkg;

    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_LEAF_SIZE  = 8;
    localparam int DEF_PATCH_SIZE = 5;
    localparam int DEF_NUM_LEAVES = 64;

    typedef logic [DEF_PATCH_SIZE-1:0][DEF_DATA_WIDTH-1:0] patch_t;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} loader_state_t;

endpackage

// File: rtl/leaves_mem_loader.sv
// leaves_mem_loader: packs LEAF_SIZE streamed patches into one leaf and writes it at an auto-incrementing address
module leaves_mem_loader
    import leaves_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
    parameter int PATCH_SIZE = DEF_PATCH_SIZE,
    parameter int NUM_LEAVES = DEF_NUM_LEAVES,
    parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
    parameter int SLOT_WIDTH = $clog2(LEAF_SIZE)
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]                in_patch,
    output logic                                                 mem_wen,
    output logic [ADDR_WIDTH-1:0]                                mem_wadr,
    output logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] mem_wdata,
    output logic                                                 busy,
    output logic                                                 done
);

    loader_state_t         state, state_d;
    logic [SLOT_WIDTH-1:0] slot;
    logic [ADDR_WIDTH-1:0] leaf_idx;
    logic                  accept, last_slot, last_leaf;

    assign accept    = in_valid && in_ready;
    assign last_slot = slot == SLOT_WIDTH'(LEAF_SIZE - 1);
    assign last_leaf = leaf_idx == ADDR_WIDTH'(NUM_LEAVES - 1);
    assign mem_wadr  = leaf_idx;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // next state: WRITE and DONE each last exactly one cycle
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (accept && last_slot) state_d = WRITE;
            WRITE:   state_d = last_leaf ? DONE : FILL;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from registered state only, so in_ready never depends on in_valid
    always_comb begin
        in_ready = state == FILL;
        mem_wen  = state == WRITE;
        busy     = state != IDLE;
        done     = state == DONE;
    end

    // slot and leaf counters; leaf_idx holds at the last leaf instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start)) begin
            slot     <= '0;
            leaf_idx <= '0;
        end else begin
            if (accept)               slot     <= last_slot ? '0 : slot + 1'b1;
            if (mem_wen && !last_leaf) leaf_idx <= leaf_idx + 1'b1;
        end
    end

    for (genvar i = 0; i < LEAF_SIZE; i++) begin : g_slot
        logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] entry;
        // each slot captures only the patch accepted while it is the current slot
        always_ff @(posedge clk) begin
            if (!rst_n)                                    entry <= '0;
            else if (accept && slot == SLOT_WIDTH'(i)) entry <= in_patch;
        end
        assign mem_wdata[i] = entry;
    end

endmodule

// File: tb/tb_leaves_mem_loader.sv
// tb_leaves_mem_loader: randomized self-checking bench against an index-arithmetic leaf model
module tb_leaves_mem_loader;
    import leaves_pkg::*;

    localparam int DW = 11;
    localparam int LS = 8;
    localparam int PS = 5;
    localparam int NL = 64;
    localparam int AW = 6;

    typedef logic [LS-1:0][PS-1:0][DW-1:0] leaf_t;
    typedef logic [3:0][PS-1:0][DW-1:0]    leaf4_t;

    logic         clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic         in_ready, mem_wen, busy, done;
    patch_t       in_patch = '0;
    logic [AW-1:0] mem_wadr;
    leaf_t        mem_wdata;

    logic         s_start = 0, s_valid = 0, s_ready, s_wen, s_busy, s_done;
    patch_t       s_patch = '0;
    logic [0:0]   s_wadr;
    leaf4_t       s_wdata;

    int    n_checks = 0, n_fail = 0, cyc = 0, start_cyc = 0, acc_cnt = 0, bad_ready = 0;
    int    wr_adr[$], wr_cyc[$], wr_acc[$], done_cyc[$];
    leaf_t wr_data[$];

    leaves_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_patch(in_patch), .mem_wen(mem_wen), .mem_wadr(mem_wadr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    leaves_mem_loader #(.LEAF_SIZE(4), .NUM_LEAVES(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_patch(s_patch), .mem_wen(s_wen), .mem_wadr(s_wadr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // passive log of every accept, write and done seen on the main instance
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
        if (mem_wen) begin
            wr_adr.push_back(int'(mem_wadr));
            wr_cyc.push_back(cyc);
            wr_acc.push_back(acc_cnt);
            wr_data.push_back(mem_wdata);
            if (in_ready) bad_ready++;
        end
        if (done) done_cyc.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic patch_t mk(input int p, input int base);
        patch_t r;
        for (int e = 0; e < PS; e++) r[e] = DW'((p * 5 + e + base) % 2048);
        return r;
    endfunction

    function automatic leaf_t exp_leaf(input int base, input int first);
        leaf_t l;
        for (int i = 0; i < LS; i++) l[i] = mk(first + i, base);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_adr.delete(); wr_cyc.delete(); wr_acc.delete(); wr_data.delete(); done_cyc.delete();
        acc_cnt = 0;
        bad_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; in_valid = 0; s_start = 0; s_valid = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic do_start();
        start = 1;
        start_cyc = cyc;
        tick();
        start = 0;
    endtask

    task automatic feed(input int n, input int gap_pct, input int base, input int first);
        int   p = 0, guard = 0;
        logic acc;
        while (p < n && guard < 20000) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) in_valid = 0;
            else begin
                in_valid = 1;
                in_patch = mk(first + p, base);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            guard++;
            if (acc) p++;
        end
        in_valid = 0;
        n_checks++;
        if (p != n) begin n_fail++; $display("FAIL feed_accepts: got %0d want %0d", p, n); end
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin @(negedge clk); k++; end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL wait_done: done not seen within %0d cycles", bound); end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick();
        n_checks += 6;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (mem_wen !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_wen: got %b want 0", mem_wen); end
        if (mem_wadr !== '0)   begin n_fail++; $display("FAIL reset_mem_wadr: got %0d want 0", mem_wadr); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (mem_wdata !== '0)  begin n_fail++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_full_load();
        clear_log();
        do_start();
        feed(LS * NL, 0, 0, 0);
        wait_done(50);
        n_checks++;
        if (wr_adr.size() != NL) begin n_fail++; $display("FAIL full_write_count: got %0d want %0d", wr_adr.size(), NL); end
        for (int k = 0; k < wr_adr.size() && k < NL; k++) begin
            n_checks += 3;
            if (wr_adr[k] != k) begin n_fail++; $display("FAIL full_addr[%0d]: got %0d want %0d", k, wr_adr[k], k); end
            if (wr_data[k] !== exp_leaf(0, LS * k)) begin n_fail++; $display("FAIL full_data[%0d]: got %0h want %0h", k, wr_data[k], exp_leaf(0, LS * k)); end
            if (wr_cyc[k] != start_cyc + 9 * (k + 1)) begin n_fail++; $display("FAIL full_timing[%0d]: got cycle %0d want %0d", k, wr_cyc[k] - start_cyc, 9 * (k + 1)); end
        end
        n_checks += 3;
        if (done_cyc.size() != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cyc.size()); end
        else if (done_cyc[0] != start_cyc + NL * (LS + 1) + 1) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc[0] - start_cyc, NL * (LS + 1) + 1); end
        if (bad_ready != 0) begin n_fail++; $display("FAIL full_ready_in_write: got %0d want 0", bad_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_after: busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_log();
        do_start();
        feed(3 * LS, 50, 0, 0);
        tick(); tick();
        n_checks += 2;
        if (wr_adr.size() != 3) begin n_fail++; $display("FAIL bp_write_count: got %0d want 3", wr_adr.size()); end
        if (bad_ready != 0) begin n_fail++; $display("FAIL bp_ready_in_write: got %0d want 0", bad_ready); end
        for (int k = 0; k < wr_adr.size() && k < 3; k++) begin
            n_checks += 3;
            if (wr_adr[k] != k) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d want %0d", k, wr_adr[k], k); end
            if (wr_data[k] !== exp_leaf(0, LS * k)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h want %0h", k, wr_data[k], exp_leaf(0, LS * k)); end
            if (wr_acc[k] != LS * (k + 1)) begin n_fail++; $display("FAIL bp_accepts[%0d]: got %0d want %0d", k, wr_acc[k], LS * (k + 1)); end
        end
        do_reset();
    endtask

    task automatic test_start_ignored();
        clear_log();
        do_start();
        feed(5 * LS + 3, 0, 0, 0);
        start = 1;
        tick();
        start = 0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_ign_ready: got %b want 1", in_ready); end
        feed(3 * LS - 3, 0, 0, 5 * LS + 3);
        tick(); tick();
        n_checks++;
        if (wr_adr.size() != 8) begin n_fail++; $display("FAIL start_ign_count: got %0d want 8", wr_adr.size()); end
        for (int k = 0; k < wr_adr.size() && k < 8; k++) begin
            n_checks += 2;
            if (wr_adr[k] != k) begin n_fail++; $display("FAIL start_ign_addr[%0d]: got %0d want %0d", k, wr_adr[k], k); end
            if (wr_data[k] !== exp_leaf(0, LS * k)) begin n_fail++; $display("FAIL start_ign_data[%0d]: got %0h want %0h", k, wr_data[k], exp_leaf(0, LS * k)); end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_fill();
        int base2;
        clear_log();
        do_start();
        feed(2 * LS + 6, 0, 0, 0);
        rst_n = 0;
        tick();
        n_checks += 6;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        if (mem_wen !== 1'b0)  begin n_fail++; $display("FAIL midrst_mem_wen: got %b want 0", mem_wen); end
        if (mem_wadr !== '0)   begin n_fail++; $display("FAIL midrst_mem_wadr: got %0d want 0", mem_wadr); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (mem_wdata !== '0)  begin n_fail++; $display("FAIL midrst_mem_wdata: got %0h want 0", mem_wdata); end
        if (wr_adr.size() != 2) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes want 2", wr_adr.size()); end
        tick();
        rst_n = 1;
        base2 = int'($urandom_range(1, 2047));
        do_start();
        feed(LS, 0, base2, 0);
        tick();
        n_checks++;
        if (wr_adr.size() != 3) begin n_fail++; $display("FAIL midrst_restart_count: got %0d want 3", wr_adr.size()); end
        else begin
            n_checks += 2;
            if (wr_adr[2] != 0) begin n_fail++; $display("FAIL midrst_restart_addr: got %0d want 0", wr_adr[2]); end
            if (wr_data[2] !== exp_leaf(base2, 0)) begin n_fail++; $display("FAIL midrst_restart_data: got %0h want %0h", wr_data[2], exp_leaf(base2, 0)); end
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        int base2;
        clear_log();
        do_start();
        feed(LS * NL, 0, 0, 0);
        wait_done(50);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy got %b want 0", busy); end
        clear_log();
        base2 = int'($urandom_range(1, 2047));
        do_start();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        feed(LS * NL, 0, base2, 0);
        wait_done(50);
        n_checks += 2;
        if (wr_adr.size() != NL) begin n_fail++; $display("FAIL b2b_write_count: got %0d want %0d", wr_adr.size(), NL); end
        if (done_cyc.size() != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cyc.size()); end
        for (int k = 0; k < wr_adr.size() && k < NL; k++) begin
            n_checks += 2;
            if (wr_adr[k] != k) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, wr_adr[k], k); end
            if (wr_data[k] !== exp_leaf(base2, LS * k)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, wr_data[k], exp_leaf(base2, LS * k)); end
        end
    endtask

    task automatic test_param_sweep();
        int     p = 0, dn = 0, dcyc = -10, busy_after = 0;
        int     wc[$], wa[$];
        leaf4_t wd[$], ew;
        s_start = 1;
        tick();
        s_start = 0;
        s_valid = 1;
        for (int c = 0; c < 40; c++) begin
            s_patch = mk(p, 7);
            @(negedge clk);
            if (dn > 0 && c > dcyc && s_busy) busy_after++;
            if (s_valid && s_ready) p++;
            if (s_wen) begin wc.push_back(c); wa.push_back(int'(s_wadr)); wd.push_back(s_wdata); end
            if (s_done) begin dn++; dcyc = c; s_start = 1; end
            tick();
            s_start = 0;
        end
        s_valid = 0;
        n_checks += 4;
        if (wa.size() != 2) begin n_fail++; $display("FAIL sweep_write_count: got %0d want 2", wa.size()); end
        if (dn != 1) begin n_fail++; $display("FAIL sweep_done_count: got %0d want 1", dn); end
        if (busy_after != 0) begin n_fail++; $display("FAIL sweep_start_in_done: busy cycles got %0d want 0", busy_after); end
        if (wc.size() < 1 || dcyc != wc[wc.size() - 1] + 1) begin n_fail++; $display("FAIL sweep_done_timing: got %0d want last write + 1", dcyc); end
        for (int k = 0; k < wa.size() && k < 2; k++) begin
            for (int i = 0; i < 4; i++) ew[i] = mk(4 * k + i, 7);
            n_checks += 2;
            if (wa[k] != k) begin n_fail++; $display("FAIL sweep_addr[%0d]: got %0d want %0d", k, wa[k], k); end
            if (wd[k] !== ew) begin n_fail++; $display("FAIL sweep_data[%0d]: got %0h want %0h", k, wd[k], ew); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_fill();
        test_back_to_back();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
